// File: rtl/reg_file_wb_sink.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_wb_sink
// Description : Register-file endpoint at the end of the write-back stage.
//               Accepts the write-back result into a 2**ADDR_W x DATA_W
//               register array and serves two registered operand reads to
//               decode. A per-register busy scoreboard is set when decode
//               issues an instruction with a destination and cleared when
//               write-back retires it; a combinational stall is raised on
//               RAW (source busy) and WAW (destination busy) hazards.
//               R0 is hardwired to zero and is never marked busy.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   : write-first. A read of the index being written on the same
//               edge captures wb_data, and a register being written back this
//               cycle no longer counts as a hazard.
//   undefined : read-before-write. A same-edge read captures the old value
//               and the stall releases one cycle after write-back.
//
// Ports
//   clk           in   1       clock, rising edge
//   rst           in   1       asynchronous active-high reset
//   wb_reg_write  in   1       write-back register write enable
//   wb_dest       in   16      write-back destination, low ADDR_W bits used
//   wb_data       in   DATA_W  write-back result
//   rd_addr1      in   ADDR_W  operand 1 index
//   rd_addr2      in   ADDR_W  operand 2 index
//   rd_data1      out  DATA_W  operand 1, registered (1-cycle latency)
//   rd_data2      out  DATA_W  operand 2, registered (1-cycle latency)
//   issue_valid   in   1       decode issuing an instruction writing issue_dest
//   issue_dest    in   ADDR_W  destination of the issuing instruction
//   stall         out  1       combinational hazard stall to decode
//   busy_vec      out  NREGS   scoreboard, bit i = Ri has a pending write
//
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_wb_sink #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_reg_write,
    input  logic [15:0]            wb_dest,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic [ADDR_W-1:0]      rd_addr1,
    input  logic [ADDR_W-1:0]      rd_addr2,
    output logic [DATA_W-1:0]      rd_data1,
    output logic [DATA_W-1:0]      rd_data2,
    input  logic                   issue_valid,
    input  logic [ADDR_W-1:0]      issue_dest,
    output logic                   stall,
    output logic [(2**ADDR_W)-1:0] busy_vec
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic [DATA_W-1:0] rd_data1_q;
    logic [DATA_W-1:0] rd_data1_d;
    logic [DATA_W-1:0] rd_data2_q;
    logic [DATA_W-1:0] rd_data2_d;

    logic [ADDR_W-1:0] w_wb_idx;
    logic [NREGS-1:0]  w_wb_hit;
    logic [NREGS-1:0]  w_clr_now;
    logic [NREGS-1:0]  w_hz_vec;
    logic              w_set_ok;
    logic              w_unused_wb_dest_hi;

    // Only the low ADDR_W bits of the destination select a register.
    assign w_wb_idx            = wb_dest[ADDR_W-1:0];
    assign w_unused_wb_dest_hi = ^wb_dest[15:ADDR_W];

    // One-hot write strobe, also used as the scoreboard clear mask.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_wb_hit
            assign w_wb_hit[gi] = wb_reg_write && (w_wb_idx == ADDR_W'(gi));
        end
    endgenerate

    // Registers retiring this cycle that may be excused from hazard checks.
`ifdef WB_BYPASS_EN
    assign w_clr_now = w_wb_hit;
`else
    assign w_clr_now = '0;
`endif

    // busy_q[0] is always 0, so index 0 can never raise a hazard.
    assign w_hz_vec = busy_q & ~w_clr_now;

    assign stall = issue_valid &&
                   (w_hz_vec[rd_addr1] || w_hz_vec[rd_addr2] || w_hz_vec[issue_dest]);

    assign w_set_ok = issue_valid && !stall && (issue_dest != '0);

    // Clear first, then set: a same-edge set of the retiring index wins
    // because the newly issued instruction now owns that register.
    always_comb begin
        busy_d = busy_q & ~w_wb_hit;
        if (w_set_ok) begin
            busy_d[issue_dest] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Operand read muxes. R0 always reads zero regardless of the array.
    always_comb begin
        rd_data1_d = regs_q[rd_addr1];
        rd_data2_d = regs_q[rd_addr2];
`ifdef WB_BYPASS_EN
        if (w_wb_hit[rd_addr1]) begin
            rd_data1_d = wb_data;
        end
        if (w_wb_hit[rd_addr2]) begin
            rd_data2_d = wb_data;
        end
`endif
        if (rd_addr1 == '0) begin
            rd_data1_d = '0;
        end
        if (rd_addr2 == '0) begin
            rd_data2_d = '0;
        end
    end

    // regs_q[0] is only ever loaded by reset, so it stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            rd_data1_q <= '0;
            rd_data2_q <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (w_wb_hit[i]) begin
                    regs_q[i] <= wb_data;
                end
            end
            busy_q     <= busy_d;
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
        end
    end

    assign rd_data1 = rd_data1_q;
    assign rd_data2 = rd_data2_q;
    assign busy_vec = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wb_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_wb_sink
// Description : Directed self-checking bench for reg_file_wb_sink. Inputs are
//               driven 1 time unit after the rising edge; registered outputs
//               and the combinational stall are sampled at that point.
//               Expected values follow the build's WB_BYPASS_EN setting.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_wb_sink;

    logic        clk;
    logic        rst;
    logic        wb_reg_write;
    logic [15:0] wb_dest;
    logic [15:0] wb_data;
    logic [3:0]  rd_addr1;
    logic [3:0]  rd_addr2;
    logic [15:0] rd_data1;
    logic [15:0] rd_data2;
    logic        issue_valid;
    logic [3:0]  issue_dest;
    logic        stall;
    logic [15:0] busy_vec;

    int checks;
    int errors;

    reg_file_wb_sink #(
        .DATA_W(16),
        .ADDR_W(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_reg_write(wb_reg_write),
        .wb_dest     (wb_dest),
        .wb_data     (wb_data),
        .rd_addr1    (rd_addr1),
        .rd_addr2    (rd_addr2),
        .rd_data1    (rd_data1),
        .rd_data2    (rd_data2),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .stall       (stall),
        .busy_vec    (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        wb_reg_write = 1'b0;
        wb_dest      = 16'h0000;
        wb_data      = 16'h0000;
        rd_addr1     = 4'd0;
        rd_addr2     = 4'd0;
        issue_valid  = 1'b0;
        issue_dest   = 4'd0;

        // Reset state
        #3;
        check("rst_rd1",   rd_data1, 32'h0);
        check("rst_rd2",   rd_data2, 32'h0);
        check("rst_busy",  busy_vec, 32'h0);
        check("rst_stall", stall,    32'h0);
        tick();
        rst = 1'b0;
        tick();

        // T1: write R3, read it back one edge later
        wb_reg_write = 1'b1; wb_dest = 16'd3; wb_data = 16'h1234;
        tick();
        wb_reg_write = 1'b0; rd_addr1 = 4'd3;
        tick();
        check("t1_rd1_r3", rd_data1, 32'h1234);

        // T2: R0 ignores writes, reads 0, never marked busy
        wb_reg_write = 1'b1; wb_dest = 16'd0; wb_data = 16'hFFFF;
        rd_addr1 = 4'd0; rd_addr2 = 4'd0;
        tick();
        wb_reg_write = 1'b0;
        tick();
        check("t2_rd1_r0", rd_data1, 32'h0);
        check("t2_rd2_r0", rd_data2, 32'h0);
        issue_valid = 1'b1; issue_dest = 4'd0;
        check("t2_stall_r0", stall, 32'h0);
        tick();
        check("t2_busy_r0", busy_vec, 32'h0);

        // T3: RAW on R5, stall until write-back
        issue_dest = 4'd5;
        check("t3_issue5_stall", stall, 32'h0);
        tick();
        check("t3_busy5", busy_vec, 32'h0020);
        issue_dest = 4'd6; rd_addr2 = 4'd5;
        check("t3_raw_stall", stall, 32'h1);
        tick();
        check("t3_busy_held", busy_vec, 32'h0020);
        check("t3_raw_stall_held", stall, 32'h1);
        wb_reg_write = 1'b1; wb_dest = 16'd5; wb_data = 16'h5A5A;
        #1;
`ifdef WB_BYPASS_EN
        check("t3_wb_cycle_stall", stall, 32'h0);
        tick();
        check("t3_busy_after_wb", busy_vec, 32'h0040);
        check("t3_rd2_bypass", rd_data2, 32'h5A5A);
        wb_reg_write = 1'b0; issue_valid = 1'b0;
        tick();
        check("t3_rd2_reread", rd_data2, 32'h5A5A);
`else
        check("t3_wb_cycle_stall", stall, 32'h1);
        tick();
        check("t3_busy_after_wb", busy_vec, 32'h0);
        check("t3_rd2_old", rd_data2, 32'h0);
        wb_reg_write = 1'b0;
        #1;
        check("t3_stall_drop", stall, 32'h0);
        tick();
        check("t3_busy6", busy_vec, 32'h0040);
        check("t3_rd2_reread", rd_data2, 32'h5A5A);
        issue_valid = 1'b0;
`endif
        rd_addr2 = 4'd0;
        wb_reg_write = 1'b1; wb_dest = 16'd6; wb_data = 16'h0606;
        tick();
        check("t3_busy_cleared", busy_vec, 32'h0);

        // T4: same-edge clear and set of R7, set wins; upper dest bits ignored
        wb_dest = 16'h0017; wb_data = 16'h7777;
        issue_valid = 1'b1; issue_dest = 4'd7;
        check("t4_stall", stall, 32'h0);
        tick();
        check("t4_busy7_set_wins", busy_vec, 32'h0080);
        wb_reg_write = 1'b0; issue_valid = 1'b0; rd_addr1 = 4'd7;
        tick();
        check("t4_rd1_r7", rd_data1, 32'h7777);

        // T5: WAW on R2 stalls and leaves busy alone; R9 write still lands
        rd_addr1 = 4'd0;
        issue_valid = 1'b1; issue_dest = 4'd2;
        tick();
        check("t5_busy2", busy_vec, 32'h0084);
        wb_reg_write = 1'b1; wb_dest = 16'd9; wb_data = 16'h9999;
        #1;
        check("t5_waw_stall", stall, 32'h1);
        tick();
        check("t5_busy_unchanged", busy_vec, 32'h0084);
        wb_reg_write = 1'b0; issue_valid = 1'b0; rd_addr1 = 4'd9;
        tick();
        check("t5_rd1_r9", rd_data1, 32'h9999);

        // T6: build busy=0x00F0 with R4=0xABCD, then reset mid-cycle
        rd_addr1 = 4'd0;
        wb_reg_write = 1'b1; wb_dest = 16'd2; wb_data = 16'h0000;
        tick();
        wb_dest = 16'd7;
        tick();
        wb_dest = 16'd4; wb_data = 16'hABCD;
        tick();
        check("t6_busy_clear", busy_vec, 32'h0);
        wb_reg_write = 1'b0;
        issue_valid = 1'b1;
        for (int r = 4; r < 8; r++) begin
            issue_dest = 4'(r);
            tick();
        end
        issue_valid = 1'b0;
        check("t6_busy_f0", busy_vec, 32'h00F0);
        rd_addr1 = 4'd4; rd_addr2 = 4'd4;
        tick();
        check("t6_rd1_r4", rd_data1, 32'hABCD);
        check("t6_rd2_r4", rd_data2, 32'hABCD);
        #2;
        rst = 1'b1;
        wb_reg_write = 1'b1; wb_dest = 16'd4; wb_data = 16'h1111;
        #1;
        check("t6_rst_busy", busy_vec, 32'h0);
        check("t6_rst_rd1", rd_data1, 32'h0);
        check("t6_rst_rd2", rd_data2, 32'h0);
        check("t6_rst_stall", stall, 32'h0);
        tick();
        rst = 1'b0; wb_reg_write = 1'b0;
        tick();
        check("t6_r4_after_rst", rd_data1, 32'h0);
        check("t6_busy_after_rst", busy_vec, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
